// File: rtl/jtframe_rom_arbn.sv
// jtframe_rom_arbn: N-slot ROM arbiter with a 32-bit cache line per slot feeding one SDRAM read port.
// Define JTFRAME_ROM_RR_EN for round-robin grants; fixed lowest-index priority otherwise.
module jtframe_rom_arbn #(
  parameter int SLOTS = 4,
  parameter int AW = 22,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0,
  parameter logic [SLOTS-1:0] DW16 = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*16-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [21:0]           sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic                  refresh_en
);
  localparam int GW = SLOTS > 1 ? $clog2(SLOTS) : 1;
`ifdef JTFRAME_ROM_RR_EN
  localparam logic [GW-1:0] GNT_RST = GW'(SLOTS-1);
`else
  localparam logic [GW-1:0] GNT_RST = '0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t r_state, w_next;
  logic [SLOTS-1:0] r_valid, w_hit, w_cand;
  logic [31:0]      r_line [SLOTS];
  logic [AW-2:0]    r_tag  [SLOTS];
  logic [AW-2:0]    w_tag  [SLOTS];
  logic [21:0]      w_addr [SLOTS];
  logic [AW-2:0]    r_gtag;
  logic [GW-1:0]    r_gnt, w_gnt;
  logic             r_req, w_any;
  logic [21:0]      r_addr;

  genvar i;
  generate
    for (i = 0; i < SLOTS; i++) begin : g_slot
      logic [AW-1:0] w_a;
      assign w_a = slot_addr[i*AW +: AW];
      // tags are the line index: 16-bit slots hold two words, 8-bit slots four bytes
      assign w_tag[i]  = DW16[i] ? w_a[AW-1:1] : {1'b0, w_a[AW-1:2]};
      assign w_addr[i] = OFFSETS[22*i +: 22] + {21'(w_tag[i]), 1'b0};
      assign w_hit[i]  = slot_cs[i] & r_valid[i] & (r_tag[i] == w_tag[i]);
      assign slot_dout[16*i +: 16] = DW16[i] ? (w_a[0] ? r_line[i][31:16] : r_line[i][15:0])
                                             : {8'h00, r_line[i][{w_a[1:0], 3'b000} +: 8]};
    end
  endgenerate

  assign slot_ok    = w_hit;
  assign w_cand     = slot_cs & ~w_hit;
  assign w_any      = |w_cand;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign refresh_en = (r_state == IDLE) & ~r_req;

  always_comb begin
    w_gnt = '0;
    for (int k = SLOTS-1; k >= 0; k--) begin
`ifdef JTFRAME_ROM_RR_EN
      if (w_cand[(int'(r_gnt) + 1 + k) % SLOTS]) w_gnt = GW'((int'(r_gnt) + 1 + k) % SLOTS);
`else
      if (w_cand[k]) w_gnt = GW'(k);
`endif
    end
  end

  always_comb begin
    w_next = downloading ? IDLE :
             (r_state == IDLE && w_any)     ? REQ  :
             (r_state == REQ  && sdram_ack) ? WAIT :
             (r_state == WAIT && data_rdy)  ? IDLE : r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= '0;
      r_gnt   <= GNT_RST;
      r_gtag  <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        r_line[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      r_state <= w_next;
      if (downloading) begin
        r_req   <= 1'b0;
        r_valid <= '0;
      end else begin
        if (r_state == IDLE && w_any) begin
          r_req  <= 1'b1;
          r_gnt  <= w_gnt;
          r_addr <= w_addr[w_gnt];
          r_gtag <= w_tag[w_gnt];
        end
        if (r_state == REQ && sdram_ack) r_req <= 1'b0;
        if (r_state == WAIT && data_rdy) begin
          r_line[r_gnt]  <= data_read;
          r_tag[r_gnt]   <= r_gtag;
          r_valid[r_gnt] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtframe_rom_arbn.sv
// tb_jtframe_rom_arbn: scoreboarded SDRAM model checks request addresses in order; direct checks on slot data.
module tb_jtframe_rom_arbn;
  localparam int SLOTS = 4;
  localparam int AW = 22;
  localparam logic [SLOTS*22-1:0] OFFS = {22'h000100, 22'h3FFFFE, 22'h050000, 22'h020000};
  localparam logic [SLOTS-1:0] DW = 4'b0101;

  logic clk = 0, rst = 1, downloading = 0;
  logic [SLOTS-1:0] slot_cs = '0, slot_ok;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS*16-1:0] slot_dout;
  logic sdram_req, sdram_ack, data_rdy, refresh_en;
  logic [21:0] sdram_addr;
  logic [31:0] data_read;

  jtframe_rom_arbn #(.SLOTS(SLOTS), .AW(AW), .OFFSETS(OFFS), .DW16(DW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en));

  always #5 clk = ~clk;

  typedef struct { logic [21:0] a; logic [31:0] d; } req_t;
  req_t sb_q[$];
  req_t e_r;
  int checks = 0, fails = 0, req_cnt = 0, wait_cycles = 0, snap;
  logic model_en = 1, busy = 0, in_wait = 0, req_d = 0;
  logic [31:0] cur_d;

  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic push(logic [21:0] a, logic [31:0] d);
    sb_q.push_back('{a, d});
  endtask

  task automatic set_slot(int s, logic cs, logic [AW-1:0] a);
    slot_cs[s] = cs;
    slot_addr[s*AW +: AW] = a;
  endtask

  task automatic wait_done(string n);
    int t;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0 && refresh_en) break;
    end
    checks++;
    if (t == 200) begin
      fails++;
      $display("FAIL %s_timeout: got pending %0d expected 0", n, sb_q.size());
    end
  endtask

  always @(posedge clk) begin
    if (sdram_req && !req_d) req_cnt++;
    req_d = sdram_req;
  end

  // SDRAM model: checks each presented request against the scoreboard, then acks and returns data
  initial begin
    sdram_ack = 0; data_rdy = 0; data_read = 0;
    forever begin
      @(negedge clk);
      if (model_en && sdram_req && !rst) begin
        busy = 1;
        if (sb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req: got addr %h expected no request", sdram_addr);
          cur_d = 0;
        end else begin
          e_r = sb_q.pop_front();
          check("req_addr", 32'(sdram_addr), 32'(e_r.a));
          cur_d = e_r.d;
        end
        sdram_ack = 1;
        @(negedge clk);
        sdram_ack = 0; in_wait = 1;
        repeat (wait_cycles) @(negedge clk);
        data_read = cur_d; data_rdy = 1;
        @(negedge clk);
        data_rdy = 0; in_wait = 0; busy = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_ok", 32'(slot_ok), 0);
    check("rst_dout", slot_dout[31:0], 0);
    check("rst_req", 32'(sdram_req), 0);
    check("rst_addr", 32'(sdram_addr), 0);
    check("rst_refresh", 32'(refresh_en), 1);

    push(22'h020004, 32'hBEEF1234);
    set_slot(0, 1, 22'h5);
    wait_done("t1");
    check("t1_ok", 32'(slot_ok[0]), 1);
    check("t1_dout", 32'(slot_dout[15:0]), 32'hBEEF);

    push(22'h050002, 32'hAABBCCDD);
    set_slot(1, 1, 22'h6);
    wait_done("t2");
    check("t2_ok", 32'(slot_ok[1]), 1);
    check("t2_dout", 32'(slot_dout[31:16]), 32'h00BB);
    snap = req_cnt;
    set_slot(1, 1, 22'h4);
    @(negedge clk);
    check("t2_ok_same_line", 32'(slot_ok[1]), 1);
    check("t2_dout_b0", 32'(slot_dout[31:16]), 32'h00DD);
    check("t2_slot0_kept", 32'(slot_dout[15:0]), 32'hBEEF);
    repeat (4) @(negedge clk);
    check("t2_no_new_req", req_cnt, snap);

    // all four miss together: fixed priority serves 0,1,2,3; slot2 address wraps
    push(22'h020100, 32'h11112222);
    push(22'h050020, 32'h33445566);
    push(22'h000002, 32'h77778888);
    push(22'h000108, 32'h99AABBCC);
    set_slot(0, 1, 22'h100);
    set_slot(1, 1, 22'h40);
    set_slot(2, 1, 22'h4);
    set_slot(3, 1, 22'h11);
    wait_done("t3");
    check("t3_ok", 32'(slot_ok), 32'hF);
    check("t3_dout0", 32'(slot_dout[15:0]), 32'h2222);
    check("t3_dout1", 32'(slot_dout[31:16]), 32'h0066);
    check("t3_dout2", 32'(slot_dout[47:32]), 32'h8888);
    check("t3_dout3", 32'(slot_dout[63:48]), 32'h00BB);

    wait_cycles = 3;
    push(22'h020200, 32'hCAFE0001);
    set_slot(0, 1, 22'h200);
    for (t = 0; t < 50 && !in_wait; t++) @(negedge clk);
    check("t4_reached_wait", 32'(in_wait), 1);
    slot_cs[0] = 0;
    wait_done("t4");
    check("t4_ok_cs_low", 32'(slot_ok[0]), 0);
    snap = req_cnt;
    slot_cs[0] = 1;
    @(negedge clk);
    check("t4_ok", 32'(slot_ok[0]), 1);
    check("t4_dout", 32'(slot_dout[15:0]), 32'h0001);
    repeat (4) @(negedge clk);
    check("t4_no_new_req", req_cnt, snap);
    wait_cycles = 0;

    model_en = 0;
    set_slot(0, 1, 22'h300);
    for (t = 0; t < 50 && !sdram_req; t++) @(negedge clk);
    check("t5_req", 32'(sdram_req), 1);
    check("t5_addr", 32'(sdram_addr), 32'h020300);
    check("t5_refresh_busy", 32'(refresh_en), 0);
    sdram_ack = 1;
    @(negedge clk);
    sdram_ack = 0;
    downloading = 1; data_rdy = 1; data_read = 32'hDEAD0000;
    @(negedge clk);
    data_rdy = 0;
    check("t5_req_dl", 32'(sdram_req), 0);
    check("t5_ok_dl", 32'(slot_ok), 0);
    check("t5_refresh_dl", 32'(refresh_en), 1);
    @(negedge clk);
    check("t5_idle_dl", 32'(sdram_req), 0);
    push(22'h020300, 32'h0000ABCD);
    push(22'h050020, 32'h33445566);
    push(22'h000002, 32'h77778888);
    push(22'h000108, 32'h99AABBCC);
    downloading = 0;
    model_en = 1;
    wait_done("t5");
    check("t5_ok", 32'(slot_ok), 32'hF);
    check("t5_dout0", 32'(slot_dout[15:0]), 32'hABCD);
    check("t5_dout3", 32'(slot_dout[63:48]), 32'h00BB);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
